// File: rtl/lp805x_sfr_defs.sv
// Shared definitions for the SFR get/put responder: handshake state encodings,
// default widths and timeout, and the timer-width helper.
package lp805x_sfr_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OFFER   = 2'd1,
    ST_GRANT   = 2'd2,
    ST_WAITPUT = 2'd3
  } sfr_state_e;

  localparam int DEF_DW  = 8;
  localparam int DEF_AW  = 2;
  localparam int DEF_TMO = 255;

  // Bits needed for a timer that must be able to hold the value tmo.
  function automatic int tmr_width(input int tmo);
    return (tmo < 2) ? 1 : $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/lp805x_sfr_fifo.sv
// Small synchronous-write FIFO with asynchronous head read; the head word is
// exposed continuously so the responder can present it without a read cycle.
module lp805x_sfr_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [DW-1:0] head
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A push while full is dropped here; the caller tracks the overflow.
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (cnt_r == (AW+1)'(DEPTH));
  assign empty     = (cnt_r == {(AW+1){1'b0}});
  assign count     = cnt_r;
  assign head      = mem[rd_ptr_r];

  always_ff @(posedge clk) begin
    if (!rst && do_push_s) begin
      mem[wr_ptr_r] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/lp805x_sfr_rsp.sv
// Peripheral-side responder for the SFR get/put handshake: offers the FIFO head,
// grants it while the controller reads, and retires it on the write-back pulse.
module lp805x_sfr_rsp
  import lp805x_sfr_defs::*;
#(
  parameter int DW  = DEF_DW,
  parameter int AW  = DEF_AW,
  parameter int TMO = DEF_TMO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          sfr_prrdy,
  input  logic          sfr_pget,
  output logic          sfr_pwrdy,
  output logic [DW-1:0] sfr_rdata,
  input  logic          sfr_pput,
  input  logic [DW-1:0] sfr_wdata,
  output logic          wr_valid,
  output logic [DW-1:0] wr_data,
  output logic          tmo_err
);

  localparam int TW = tmr_width(TMO);

  sfr_state_e    state_r;
  logic [TW-1:0] timer_r;
  logic          fifo_empty_s;
  logic          tmo_exp_s;
  logic          pop_s;

  // TMO of zero disables the idle timeout entirely.
  assign tmo_exp_s = (TMO != 0) && (timer_r == TW'(TMO));
  // The head is retired only when a transaction ends, with or without write-back.
  assign pop_s     = (state_r == ST_WAITPUT) && (sfr_pput || tmo_exp_s);

  lp805x_sfr_fifo #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop_s),
    .full      (full),
    .empty     (fifo_empty_s),
    .count     (count),
    .head      (sfr_rdata)
  );

  // Sticky overflow: a dropped push wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (push && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end

  // Handshake FSM with idle timer and write-back capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      timer_r   <= {TW{1'b0}};
      sfr_prrdy <= 1'b0;
      sfr_pwrdy <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= {DW{1'b0}};
      tmo_err   <= 1'b0;
    end else begin
      sfr_prrdy <= 1'b0;
      wr_valid  <= 1'b0;
      tmo_err   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            sfr_prrdy <= 1'b1;
            timer_r   <= {TW{1'b0}};
            state_r   <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (sfr_pget) begin
            sfr_pwrdy <= 1'b1;
            state_r   <= ST_GRANT;
          end else if (tmo_exp_s) begin
            tmo_err <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        ST_GRANT: begin
          if (!sfr_pget) begin
            sfr_pwrdy <= 1'b0;
            timer_r   <= {TW{1'b0}};
            state_r   <= ST_WAITPUT;
          end
        end
        ST_WAITPUT: begin
          if (sfr_pput) begin
            wr_data  <= sfr_wdata;
            wr_valid <= 1'b1;
            state_r  <= ST_IDLE;
          end else if (tmo_exp_s) begin
            tmo_err <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        default: begin
          sfr_pwrdy <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lp805x_sfr_rsp.sv
// Self-checking bench for lp805x_sfr_rsp: random data through a queue-based
// reference of the buffered words, overflow flag and write-back value.
module tb_lp805x_sfr_rsp;

  localparam int DW  = 8;
  localparam int AW  = 2;
  localparam int TMO = 8;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          push;
  logic [DW-1:0] push_data;
  logic          full;
  logic [AW:0]   count;
  logic          ovf;
  logic          ovf_clr;
  logic          sfr_prrdy;
  logic          sfr_pget;
  logic          sfr_pwrdy;
  logic [DW-1:0] sfr_rdata;
  logic          sfr_pput;
  logic [DW-1:0] sfr_wdata;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          tmo_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: words buffered in order, sticky overflow, last written-back word.
  logic [DW-1:0] q[$];
  bit            ovf_m;
  logic [DW-1:0] last_wd;

  lp805x_sfr_rsp #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .full      (full),
    .count     (count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .sfr_prrdy (sfr_prrdy),
    .sfr_pget  (sfr_pget),
    .sfr_pwrdy (sfr_pwrdy),
    .sfr_rdata (sfr_rdata),
    .sfr_pput  (sfr_pput),
    .sfr_wdata (sfr_wdata),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .tmo_err   (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push = 1'b1;
    push_data = d;
    tick();
    push = 1'b0;
    if (q.size() == DEPTH) ovf_m = 1'b1;
    else q.push_back(d);
  endtask

  task automatic wait_offer(input string tag);
    int w;
    w = 0;
    while (sfr_prrdy !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    n_tests++;
    if (sfr_prrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_offer_wait: prrdy=%b after %0d cycles, expected 1", tag, sfr_prrdy, w);
    end
  endtask

  // Full transaction; optionally pushes cdata in the same cycle as the write-back.
  task automatic do_txn(input logic [DW-1:0] wd, input bit cpush, input logic [DW-1:0] cdata);
    logic [DW-1:0] exp_head;
    logic [AW:0]   exp_cnt;
    int            hold;
    bit            was_full;
    wait_offer("txn");
    exp_head = q[0];
    n_tests++;
    if (sfr_rdata !== exp_head) begin
      n_fail++;
      $display("FAIL txn_rdata_offer: got %h expected %h", sfr_rdata, exp_head);
    end
    sfr_pget = 1'b1;
    tick();
    n_tests++;
    if (sfr_pwrdy !== 1'b1 || sfr_prrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL txn_grant: pwrdy=%b prrdy=%b expected 1/0", sfr_pwrdy, sfr_prrdy);
    end
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      tick();
      n_tests++;
      if (sfr_pwrdy !== 1'b1 || sfr_rdata !== exp_head) begin
        n_fail++;
        $display("FAIL txn_hold: pwrdy=%b rdata=%h expected 1/%h", sfr_pwrdy, sfr_rdata, exp_head);
      end
    end
    sfr_pget = 1'b0;
    tick();
    n_tests++;
    if (sfr_pwrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL txn_release: pwrdy=%b expected 0", sfr_pwrdy);
    end
    repeat ($urandom_range(0, 3)) tick();
    sfr_pput  = 1'b1;
    sfr_wdata = wd;
    if (cpush) begin
      push = 1'b1;
      push_data = cdata;
    end
    tick();
    sfr_pput  = 1'b0;
    push      = 1'b0;
    sfr_wdata = DW'($urandom);
    was_full = (q.size() == DEPTH);
    void'(q.pop_front());
    if (cpush) begin
      if (was_full) ovf_m = 1'b1;
      else q.push_back(cdata);
    end
    last_wd = wd;
    exp_cnt = (AW+1)'(q.size());
    n_tests++;
    if (wr_valid !== 1'b1 || wr_data !== wd || count !== exp_cnt) begin
      n_fail++;
      $display("FAIL txn_writeback: wr_valid=%b wr_data=%h count=%0d expected 1/%h/%0d",
               wr_valid, wr_data, count, wd, exp_cnt);
    end
    tick();
    n_tests++;
    if (wr_valid !== 1'b0 || sfr_prrdy !== (q.size() != 0)) begin
      n_fail++;
      $display("FAIL txn_after: wr_valid=%b prrdy=%b expected 0/%b",
               wr_valid, sfr_prrdy, (q.size() != 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; push_data = '0; ovf_clr = 1'b0;
    sfr_pget = 1'b0; sfr_pput = 1'b0; sfr_wdata = '0;
    q.delete(); ovf_m = 1'b0; last_wd = '0;
    tick();
    tick();
    n_tests++;
    if (sfr_prrdy !== 1'b0 || sfr_pwrdy !== 1'b0 || count !== 3'd0 || full !== 1'b0 ||
        ovf !== 1'b0 || wr_valid !== 1'b0 || wr_data !== 8'h00 || tmo_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: prrdy=%b pwrdy=%b count=%0d full=%b ovf=%b wr_valid=%b wr_data=%h tmo=%b expected all 0",
               sfr_prrdy, sfr_pwrdy, count, full, ovf, wr_valid, wr_data, tmo_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    push_word(8'hA5);
    n_tests++;
    if (count !== 3'd1 || sfr_prrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_latency1: count=%0d prrdy=%b expected 1/0", count, sfr_prrdy);
    end
    tick();
    n_tests++;
    if (sfr_prrdy !== 1'b1 || sfr_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_latency2: prrdy=%b rdata=%h expected 1/a5", sfr_prrdy, sfr_rdata);
    end
    do_txn(8'h3C, 1'b0, 8'h00);
    n_tests++;
    if (count !== 3'd0 || wr_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL single_end: count=%0d wr_data=%h expected 0/3c", count, wr_data);
    end
  endtask

  task automatic test_ignored();
    sfr_pput = 1'b1; sfr_pget = 1'b1; sfr_wdata = DW'($urandom);
    tick();
    sfr_pput = 1'b0;
    tick();
    n_tests++;
    if (wr_valid !== 1'b0 || sfr_pwrdy !== 1'b0 || count !== 3'd0 || wr_data !== last_wd) begin
      n_fail++;
      $display("FAIL ignored: wr_valid=%b pwrdy=%b count=%0d wr_data=%h expected 0/0/0/%h",
               wr_valid, sfr_pwrdy, count, wr_data, last_wd);
    end
    sfr_pget = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      push_word(DW'($urandom));
      n_tests++;
      if (full !== (q.size() == DEPTH) || ovf !== ovf_m) begin
        n_fail++;
        $display("FAIL ovf_fill%0d: full=%b ovf=%b expected %b/%b",
                 i, full, ovf, (q.size() == DEPTH), ovf_m);
      end
    end
    push = 1'b1; push_data = DW'($urandom); ovf_clr = 1'b1;
    tick();
    push = 1'b0; ovf_clr = 1'b0;
    n_tests++;
    if (ovf !== 1'b1 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_clr_collide: ovf=%b count=%0d expected 1/4", ovf, count);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    ovf_m = 1'b0;
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: ovf=%b expected 0", ovf);
    end
    for (int i = 0; i < 4; i++) do_txn(DW'($urandom), 1'b0, 8'h00);
    n_tests++;
    if (count !== 3'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_drain: count=%0d full=%b expected 0/0", count, full);
    end
  endtask

  task automatic test_wrap();
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    for (int i = 0; i < 10; i++) do_txn(DW'($urandom), 1'b1, DW'($urandom));
    do_txn(DW'($urandom), 1'b0, 8'h00);
    do_txn(DW'($urandom), 1'b0, 8'h00);
    n_tests++;
    if (count !== 3'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: count=%0d ovf=%b expected 0/0", count, ovf);
    end
  endtask

  task automatic test_offer_timeout();
    int n;
    push_word(DW'($urandom));
    wait_offer("otmo");
    n = 0;
    while (tmo_err !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != TMO + 1 || count !== 3'd1 || sfr_prrdy !== 1'b0) begin
      n_fail++;
      $display("FAIL offer_timeout: cycles=%0d count=%0d prrdy=%b expected %0d/1/0",
               n, count, sfr_prrdy, TMO + 1);
    end
    tick();
    n_tests++;
    if (sfr_prrdy !== 1'b1 || tmo_err !== 1'b0) begin
      n_fail++;
      $display("FAIL offer_reoffer: prrdy=%b tmo_err=%b expected 1/0", sfr_prrdy, tmo_err);
    end
    do_txn(DW'($urandom), 1'b0, 8'h00);
  endtask

  task automatic test_put_timeout();
    int n;
    bit saw_wv;
    push_word(DW'($urandom));
    wait_offer("ptmo");
    sfr_pget = 1'b1;
    tick();
    sfr_pget = 1'b0;
    tick();
    n = 0;
    saw_wv = 1'b0;
    while (tmo_err !== 1'b1 && n < 30) begin
      tick();
      n++;
      if (wr_valid === 1'b1) saw_wv = 1'b1;
    end
    void'(q.pop_front());
    n_tests++;
    if (n != TMO + 1 || count !== 3'd0 || saw_wv || wr_data !== last_wd) begin
      n_fail++;
      $display("FAIL put_timeout: cycles=%0d count=%0d wr_valid_seen=%b wr_data=%h expected %0d/0/0/%h",
               n, count, saw_wv, wr_data, TMO + 1, last_wd);
    end
    tick();
    n_tests++;
    if (sfr_prrdy !== 1'b0 || tmo_err !== 1'b0) begin
      n_fail++;
      $display("FAIL put_timeout_after: prrdy=%b tmo_err=%b expected 0/0", sfr_prrdy, tmo_err);
    end
  endtask

  task automatic test_reset_in_grant();
    push_word(DW'($urandom));
    push_word(DW'($urandom));
    wait_offer("rst");
    sfr_pget = 1'b1;
    tick();
    n_tests++;
    if (sfr_pwrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_grant_entry: pwrdy=%b expected 1", sfr_pwrdy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sfr_pget = 1'b0;
    q.delete();
    last_wd = '0;
    n_tests++;
    if (sfr_pwrdy !== 1'b0 || sfr_prrdy !== 1'b0 || count !== 3'd0 || wr_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_grant: pwrdy=%b prrdy=%b count=%0d wr_data=%h expected 0/0/0/00",
               sfr_pwrdy, sfr_prrdy, count, wr_data);
    end
    repeat (3) begin
      tick();
      n_tests++;
      if (sfr_prrdy !== 1'b0 || sfr_pwrdy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_idle: prrdy=%b pwrdy=%b expected 0/0", sfr_prrdy, sfr_pwrdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored();
    test_overflow();
    test_wrap();
    test_offer_timeout();
    test_put_timeout();
    test_reset_in_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
